// File: rtl/md6_pkg.sv
// md6_pkg: MD6 round-scheduler widths, constants, FSM encoding and S_j recurrence
package md6_pkg;
  localparam int W = 64;
  localparam int C = 16;
  localparam int R_MAX = 168;
  localparam int RW = 8;
  localparam int TW = 12;
  localparam int CW = $clog2(C);
  localparam logic [W-1:0] S0 = 64'h0123456789abcdef;
  localparam logic [W-1:0] S_STAR = 64'h7311c2812425cfa0;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic logic [W-1:0] md6_s_next(input logic [W-1:0] s);
    return {s[W-2:0], s[W-1]} ^ (s & S_STAR);
  endfunction
endpackage

// File: rtl/md6_s_gen.sv
// md6_s_gen: round-constant register; clk/rst, load restores S0, adv applies recurrence, s is S_j
module md6_s_gen
  import md6_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         adv,
  output logic [W-1:0] s
);
  always_ff @(posedge clk)
    if (rst || load) s <= S0;
    else if (adv) s <= md6_s_next(s);
endmodule

// File: rtl/md6_round_sched.sv
// md6_round_sched: MD6 step sequencer; start/rounds in, busy/done out, step descriptor (idx, round, S_j, last) over step_valid/step_ready
module md6_round_sched
  import md6_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [RW-1:0] rounds,
  output logic          busy,
  output logic          step_valid,
  input  logic          step_ready,
  output logic [TW-1:0] step_idx,
  output logic [RW-1:0] round_idx,
  output logic [W-1:0]  s_word,
  output logic          step_last,
  output logic          done
);
  state_t state, state_n;
  logic [RW-1:0] r_eff, r_in, j;
  logic [CW-1:0] i;
  logic [TW-1:0] t;
  logic fire, at_end, load, adv;
  assign r_in = rounds > RW'(R_MAX) ? RW'(R_MAX) : rounds;
  assign fire = state == RUN && step_ready;
  assign at_end = i == CW'(C - 1);
  assign load = state == IDLE && start;
  assign adv = fire && at_end;
  assign busy = state != IDLE;
  assign step_valid = state == RUN;
  assign done = state == DONE;
  assign step_last = state == RUN && at_end && j == r_eff - RW'(1);
  assign step_idx = t;
  assign round_idx = j;
  always_comb begin
    state_n = IDLE;
    state_n = state == IDLE ? (start ? (r_in == '0 ? DONE : RUN) : IDLE) :
              state == RUN  ? (fire && step_last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      r_eff <= '0;
      i <= '0;
      j <= '0;
      t <= '0;
    end else begin
      state <= state_n;
      if (load) begin
        r_eff <= r_in;
        i <= '0;
        j <= '0;
        t <= '0;
      end else if (fire) begin
        t <= t + TW'(1);
        i <= at_end ? '0 : i + CW'(1);
        j <= at_end ? j + RW'(1) : j;
      end
    end
  md6_s_gen u_s_gen (
    .clk (clk),
    .rst (rst),
    .load(load),
    .adv (adv),
    .s   (s_word)
  );
endmodule
